// File: rtl/vfu_inv_sequencer.sv
// vfu_inv_sequencer: watches vector-unit AW bursts, issues one data-cache
// line invalidation per line each burst touches, and holds the burst's B
// response until all of that burst's invalidations are acknowledged.
// Optional macro VFU_INV_PERF_EN adds the perf_inv_count / perf_stall_count
// counters and their output ports.
module vfu_inv_sequencer #(
  parameter int LINE_BYTES = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_awvalid,
  output logic              m_awready,
  input  logic [ADDR_W-1:0] m_awaddr,
  input  logic [7:0]        m_awlen,
  input  logic [2:0]        m_awsize,
  output logic              s_awvalid,
  input  logic              s_awready,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic              m_bvalid,
  input  logic              m_bready,
  output logic              inv_valid,
  output logic [ADDR_W-1:0] inv_addr,
  input  logic              inv_ack
`ifdef VFU_INV_PERF_EN
  ,
  output logic [31:0]       perf_inv_count,
  output logic [31:0]       perf_stall_count
`endif
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SLOTS = 1 << PTR_W;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_line;
  logic [ADDR_W-1:0] end_line;

  logic [ADDR_W-1:0] fifo_addr [SLOTS];
  logic [7:0]        fifo_len  [SLOTS];
  logic [2:0]        fifo_size [SLOTS];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  credit;

  logic              full;
  logic              fifo_empty;
  logic              aw_fire;
  logic              b_fire;
  logic              pop;
  logic              credit_inc;
  logic              credit_avail;

  logic [ADDR_W-1:0] head_addr;
  logic [ADDR_W-1:0] burst_bytes;
  logic [ADDR_W-1:0] last_byte;
  logic [ADDR_W-1:0] head_first;
  logic [ADDR_W-1:0] head_last;

  // Handshake gating: full comes from the registered count, so no comb loop
  assign full         = (outstanding == CNT_W'(FIFO_DEPTH));
  assign credit_avail = (credit != '0);
  assign s_awvalid    = m_awvalid & ~full;
  assign m_awready    = s_awready & ~full;
  assign m_bvalid     = s_bvalid & credit_avail;
  assign s_bready     = m_bready & credit_avail;
  assign aw_fire      = s_awvalid & s_awready;
  assign b_fire       = s_bvalid & s_bready;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = (state == IDLE) && !fifo_empty;
  assign credit_inc = (state == ISSUE) && inv_ack && (cur_line == end_line);

  // Line range of the burst at the FIFO head
  assign head_addr   = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign burst_bytes = (ADDR_W'(fifo_len[rd_ptr[PTR_W-1:0]]) + ADDR_W'(1))
                       << fifo_size[rd_ptr[PTR_W-1:0]];
  assign last_byte   = head_addr + burst_bytes - ADDR_W'(1);
  assign head_first  = head_addr >> OFF_W;
  assign head_last   = last_byte >> OFF_W;

  // Burst storage; payload needs no reset since the pointers qualify it
  always_ff @(posedge clk) begin
    if (aw_fire) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= m_awaddr;
      fifo_len[wr_ptr[PTR_W-1:0]]  <= m_awlen;
      fifo_size[wr_ptr[PTR_W-1:0]] <= m_awsize;
    end
  end

  // FIFO pointers advance on AW capture and on FSM pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (aw_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Outstanding writes: AW accepted but B not yet delivered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({aw_fire, b_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Credits: bursts fully invalidated whose B has not yet been released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= '0;
    end else begin
      case ({credit_inc, b_fire})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  // Invalidation FSM: pop a burst, walk its lines, hold each until acked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_line  <= '0;
      end_line  <= '0;
      inv_valid <= 1'b0;
      inv_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_line  <= head_first;
            end_line  <= head_last;
            inv_addr  <= head_first << OFF_W;
            inv_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (inv_ack) begin
            if (cur_line != end_line) begin
              cur_line <= cur_line + ADDR_W'(1);
              inv_addr <= (cur_line + ADDR_W'(1)) << OFF_W;
            end else begin
              inv_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          inv_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef VFU_INV_PERF_EN
  // Performance counters: accepted invalidations and stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_inv_count   <= '0;
      perf_stall_count <= '0;
    end else begin
      if (inv_valid && inv_ack)
        perf_inv_count <= perf_inv_count + 32'd1;
      if ((inv_valid && !inv_ack) || (s_bvalid && !credit_avail))
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule
